pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the 5-stage CPU. It resolves operand forwarding and load-use hazards for the ID stage, and stalls the pipeline on multi-cycle instruction/data memory handshakes. It selects between delay-slot and flush branch modes and detects memory timeouts. It also keeps saturating stall/flush performance counters, and drives the per-stage reset/enable pairs of IF, ID, EXE, MEM and WB.

---
 rtl/pipe_hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall control for the 5-stage pipeline: forwarding selects, per-stage
// bubble/hold controls, memory-wait FSM with timeout, stall/flush counters.
// Optional single-step debug halt is built when PIPE_DEBUG_STEP_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned AW                = 5,
  parameter int unsigned CW                = 32,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned BRANCH_DELAY_SLOT = 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PIPE_DEBUG_STEP_EN
  input  logic          debug_en,
  input  logic          debug_step,
`endif
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          rs_used,
  input  logic          rt_used,
  input  logic          is_store_id,
  input  logic          branch_taken_id,
  input  logic [AW-1:0] regw_addr_exe,
  input  logic [AW-1:0] regw_addr_mem,
  input  logic          wb_wen_exe,
  input  logic          wb_wen_mem,
  input  logic          is_load_exe,
  input  logic          is_load_mem,
  input  logic          imem_ready,
  input  logic          dmem_req_mem,
  input  logic          dmem_ready,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          fwd_m,
  output logic          if_rst,
  output logic          id_rst,
  output logic          exe_rst,
  output logic          mem_rst,
  output logic          wb_rst,
  output logic          if_en,
  output logic          id_en,
  output logic          exe_en,
  output logic          mem_en,
  output logic          wb_en,
  output logic          mem_fault,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  localparam int unsigned TW  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned WCW = (TW > 8) ? TW : 8;
  localparam logic        FLUSH_MODE = (BRANCH_DELAY_SLOT == 0);

  typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;

  state_t           state, state_nx;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nx, wait_inc;
  logic             fault_nx;
  logic             halt;
  logic             dwait, iwait, wait_any;
  logic             load_stall;
  logic             stall_evt, flush_evt;
  logic [1:0]       sel_a, sel_b;
  logic             sel_m, ls_a, ls_b;
  logic             rs_live, rt_live;

`ifdef PIPE_DEBUG_STEP_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= debug_step;
  end

  // A rising edge of debug_step lets exactly one cycle through.
  assign halt = debug_en & ~(debug_step & ~step_q);
`else
  assign halt = 1'b0;
`endif

  assign dwait    = dmem_req_mem & ~dmem_ready;
  assign iwait    = ~imem_ready;
  assign wait_any = dwait | iwait;

  // Operand forwarding; EXE producer takes precedence over MEM producer.
  always_comb begin
    sel_a   = 2'd0;
    sel_b   = 2'd0;
    sel_m   = 1'b0;
    ls_a    = 1'b0;
    ls_b    = 1'b0;
    rs_live = rs_used && (rs_addr != '0);
    rt_live = rt_used && (rt_addr != '0);
    if (rs_live && wb_wen_exe && (regw_addr_exe == rs_addr)) begin
      if (is_load_exe) ls_a  = 1'b1;
      else             sel_a = 2'd1;
    end else if (rs_live && wb_wen_mem && (regw_addr_mem == rs_addr)) begin
      sel_a = is_load_mem ? 2'd3 : 2'd2;
    end
    if (rt_live && wb_wen_exe && (regw_addr_exe == rt_addr)) begin
      if (!is_load_exe)     sel_b = 2'd1;
      else if (is_store_id) sel_m = 1'b1;
      else                  ls_b  = 1'b1;
    end else if (rt_live && wb_wen_mem && (regw_addr_mem == rt_addr)) begin
      sel_b = is_load_mem ? 2'd3 : 2'd2;
    end
  end

  assign load_stall = ls_a | ls_b;

  always_comb begin
    fwd_a = rst ? 2'd0 : sel_a;
    fwd_b = rst ? 2'd0 : sel_b;
    fwd_m = rst ? 1'b0 : sel_m;
  end

  // Stage controls, first matching rule wins.
  always_comb begin
    if_rst    = 1'b0;
    id_rst    = 1'b0;
    exe_rst   = 1'b0;
    mem_rst   = 1'b0;
    wb_rst    = 1'b0;
    if_en     = 1'b1;
    id_en     = 1'b1;
    exe_en    = 1'b1;
    mem_en    = 1'b1;
    wb_en     = 1'b1;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (rst) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (halt || (state == FAULT)) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (dwait) begin
      if_en     = 1'b0;
      id_en     = 1'b0;
      exe_en    = 1'b0;
      mem_en    = 1'b0;
      wb_rst    = 1'b1;
      stall_evt = 1'b1;
    end else if (load_stall || (iwait && branch_taken_id)) begin
      if_en     = 1'b0;
      id_en     = 1'b0;
      exe_rst   = 1'b1;
      stall_evt = 1'b1;
    end else if (iwait) begin
      if_en     = 1'b0;
      id_rst    = 1'b1;
      stall_evt = 1'b1;
    end else if (branch_taken_id && FLUSH_MODE) begin
      id_rst    = 1'b1;
      flush_evt = 1'b1;
    end
  end

  assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + WCW'(1);

  // The timeout is checked on the incremented count so mem_fault rises on the
  // same edge that wait_cnt reaches MEM_TIMEOUT, whatever state it came from.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    fault_nx    = mem_fault;
    if ((state != FAULT) && !halt) begin
      wait_cnt_nx = wait_any ? wait_inc : '0;
      case (state)
        RUN:     if (wait_any)  state_nx = WAIT;
        WAIT:    if (!wait_any) state_nx = RUN;
        default: state_nx = state;
      endcase
      if (wait_any && (MEM_TIMEOUT != 0) && (wait_inc == WCW'(MEM_TIMEOUT))) begin
        state_nx = FAULT;
        fault_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      mem_fault <= fault_nx;
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CW'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (flush mode with short timeout,
// delay-slot mode with 4-bit counters and no timeout) driven by shared inputs.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_addr, rt_addr, regw_addr_exe, regw_addr_mem;
  logic rs_used, rt_used, is_store_id, branch_taken_id;
  logic wb_wen_exe, wb_wen_mem, is_load_exe, is_load_mem;
  logic imem_ready, dmem_req_mem, dmem_ready;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic fm0, fm1, mf0, mf1;
  logic [4:0] rv0, ev0, rv1, ev1;
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;

  // reference state per instance
  bit              m_fault [2];
  int unsigned     m_wc    [2];
  longint unsigned m_stall [2];
  longint unsigned m_flush [2];
  int unsigned     p_mt    [2] = '{4, 0};
  int unsigned     p_bds   [2] = '{0, 1};
  longint unsigned p_cmax  [2] = '{64'hFFFF_FFFF, 64'd15};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.AW(5), .CW(32), .MEM_TIMEOUT(4), .BRANCH_DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used),
    .rt_used(rt_used), .is_store_id(is_store_id), .branch_taken_id(branch_taken_id),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_exe(wb_wen_exe),
    .wb_wen_mem(wb_wen_mem), .is_load_exe(is_load_exe), .is_load_mem(is_load_mem),
    .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .fwd_a(fa0), .fwd_b(fb0), .fwd_m(fm0),
    .if_rst(rv0[4]), .id_rst(rv0[3]), .exe_rst(rv0[2]), .mem_rst(rv0[1]), .wb_rst(rv0[0]),
    .if_en(ev0[4]), .id_en(ev0[3]), .exe_en(ev0[2]), .mem_en(ev0[1]), .wb_en(ev0[0]),
    .mem_fault(mf0), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_hazard_ctrl #(.AW(5), .CW(4), .MEM_TIMEOUT(0), .BRANCH_DELAY_SLOT(1)) dut1 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used),
    .rt_used(rt_used), .is_store_id(is_store_id), .branch_taken_id(branch_taken_id),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .wb_wen_exe(wb_wen_exe),
    .wb_wen_mem(wb_wen_mem), .is_load_exe(is_load_exe), .is_load_mem(is_load_mem),
    .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .fwd_a(fa1), .fwd_b(fb1), .fwd_m(fm1),
    .if_rst(rv1[4]), .id_rst(rv1[3]), .exe_rst(rv1[2]), .mem_rst(rv1[1]), .wb_rst(rv1[0]),
    .if_en(ev1[4]), .id_en(ev1[3]), .exe_en(ev1[2]), .mem_en(ev1[1]), .wb_en(ev1[0]),
    .mem_fault(mf1), .stall_cnt(sc1), .flush_cnt(fc1));

  // ---------------- reference model ----------------
  function automatic void fwd_ref(input logic [4:0] a, input logic used, input bit is_rt,
                                  output logic [1:0] sel, output bit ls, output bit fm);
    sel = 2'd0; ls = 0; fm = 0;
    if (used && a != 5'd0) begin
      if (wb_wen_exe && regw_addr_exe == a) begin
        if (!is_load_exe) sel = 2'd1;
        else if (is_rt && is_store_id) fm = 1;
        else ls = 1;
      end else if (wb_wen_mem && regw_addr_mem == a) begin
        sel = is_load_mem ? 2'd3 : 2'd2;
      end
    end
  endfunction

  // 0 run, 1 reset, 2 frozen, 3 dmem wait, 4 load/branch stall, 5 fetch wait, 6 flush
  function automatic int action(input int d);
    logic [1:0] s; bit la, lb, fm;
    fwd_ref(rs_addr, rs_used, 0, s, la, fm);
    fwd_ref(rt_addr, rt_used, 1, s, lb, fm);
    if (rst) return 1;
    if (m_fault[d]) return 2;
    if (dmem_req_mem && !dmem_ready) return 3;
    if (la || lb || (!imem_ready && branch_taken_id)) return 4;
    if (!imem_ready) return 5;
    if (branch_taken_id && p_bds[d] == 0) return 6;
    return 0;
  endfunction

  // bit order {if, id, exe, mem, wb}
  function automatic logic [4:0] exp_rst(input int act);
    case (act)
      1: return 5'b11111;
      3: return 5'b00001;
      4: return 5'b00100;
      5, 6: return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] exp_en(input int act);
    case (act)
      2: return 5'b00000;
      3: return 5'b00001;
      4: return 5'b00111;
      5: return 5'b01111;
      default: return 5'b11111;
    endcase
  endfunction

  function automatic logic [4:0] exp_fwd();
    logic [1:0] sa, sb; bit la, lb, fa, fb;
    fwd_ref(rs_addr, rs_used, 0, sa, la, fa);
    fwd_ref(rt_addr, rt_used, 1, sb, lb, fb);
    if (rst) return 5'd0;
    return {sa, sb, fb};
  endfunction

  // Advance the model by one clock, then the DUT; returns at the next negedge.
  task automatic step();
    int act;
    for (int d = 0; d < 2; d++) begin
      act = action(d);
      if (rst) begin
        m_fault[d] = 0; m_wc[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
      end else if (!m_fault[d]) begin
        if ((dmem_req_mem && !dmem_ready) || !imem_ready) begin
          if (m_wc[d] < 255) m_wc[d]++;
          if (p_mt[d] != 0 && m_wc[d] == p_mt[d]) m_fault[d] = 1;
        end else m_wc[d] = 0;
        if (act >= 3 && act <= 5 && m_stall[d] < p_cmax[d]) m_stall[d]++;
        if (act == 6 && m_flush[d] < p_cmax[d]) m_flush[d]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs_addr = 0; rt_addr = 0; regw_addr_exe = 0; regw_addr_mem = 0;
    rs_used = 0; rt_used = 0; is_store_id = 0; branch_taken_id = 0;
    wb_wen_exe = 0; wb_wen_mem = 0; is_load_exe = 0; is_load_mem = 0;
    imem_ready = 1; dmem_req_mem = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; step(); rst = 0; #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1; rs_used = 1; rs_addr = 3; wb_wen_exe = 1; regw_addr_exe = 3; #1;
    checks++; if (rv0 !== 5'b11111) begin errors++; $display("FAIL reset_rst: got %b expected 11111", rv0); end
    checks++; if (fa0 !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d expected 0", fa0); end
    step();
    rst = 0; clear_inputs(); #1;
    checks++; if (sc0 !== 32'd0 || fc0 !== 32'd0) begin errors++; $display("FAIL reset_cnt0: got %0d/%0d expected 0/0", sc0, fc0); end
    checks++; if (sc1 !== 4'd0 || fc1 !== 4'd0) begin errors++; $display("FAIL reset_cnt1: got %0d/%0d expected 0/0", sc1, fc1); end
    checks++; if (mf0 !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", mf0); end
    checks++; if (ev0 !== 5'b11111 || rv0 !== 5'b00000) begin errors++; $display("FAIL reset_idle: got en=%b rst=%b expected 11111/00000", ev0, rv0); end
  endtask

  task automatic test_forward();
    do_reset();
    wb_wen_exe = 1; regw_addr_exe = 3; rs_used = 1; rs_addr = 3; #1;
    checks++; if (fa0 !== 2'd1) begin errors++; $display("FAIL fwd_exe: got %0d expected 1", fa0); end
    checks++; if (ev0 !== 5'b11111) begin errors++; $display("FAIL fwd_exe_nostall: got %b expected 11111", ev0); end
    step();
    wb_wen_exe = 0; wb_wen_mem = 1; regw_addr_mem = 3; #1;
    checks++; if (fa0 !== 2'd2) begin errors++; $display("FAIL fwd_mem: got %0d expected 2", fa0); end
    rs_addr = 0; regw_addr_mem = 0; #1;
    checks++; if (fa0 !== 2'd0) begin errors++; $display("FAIL fwd_x0: got %0d expected 0", fa0); end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    wb_wen_exe = 1; is_load_exe = 1; regw_addr_exe = 5; rt_used = 1; rt_addr = 5; #1;
    checks++; if (ev0 !== 5'b00111 || rv0 !== 5'b00100) begin errors++; $display("FAIL load_use_stall: got en=%b rst=%b expected 00111/00100", ev0, rv0); end
    step();
    wb_wen_exe = 0; is_load_exe = 0; wb_wen_mem = 1; is_load_mem = 1; regw_addr_mem = 5; #1;
    checks++; if (fb0 !== 2'd3) begin errors++; $display("FAIL load_use_fwd: got %0d expected 3", fb0); end
    checks++; if (sc0 !== 32'd1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", sc0); end
    checks++; if (ev0 !== 5'b11111) begin errors++; $display("FAIL load_use_resume: got %b expected 11111", ev0); end
    step();
    clear_inputs();
    wb_wen_exe = 1; is_load_exe = 1; regw_addr_exe = 5; rt_used = 1; rt_addr = 5; is_store_id = 1; #1;
    checks++; if (fm0 !== 1'b1 || fb0 !== 2'd0) begin errors++; $display("FAIL store_fwd_m: got m=%b b=%0d expected 1/0", fm0, fb0); end
    checks++; if (ev0 !== 5'b11111) begin errors++; $display("FAIL store_nostall: got %b expected 11111", ev0); end
    step();
    checks++; if (sc0 !== 32'd1) begin errors++; $display("FAIL store_cnt: got %0d expected 1", sc0); end
  endtask

  task automatic test_dwait();
    do_reset();
    dmem_req_mem = 1; dmem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (ev0 !== 5'b00001 || rv0 !== 5'b00001) begin errors++; $display("FAIL dwait_%0d: got en=%b rst=%b expected 00001/00001", k, ev0, rv0); end
      step();
    end
    dmem_ready = 1; #1;
    checks++; if (ev0 !== 5'b11111 || rv0 !== 5'b00000) begin errors++; $display("FAIL dwait_done: got en=%b rst=%b expected 11111/00000", ev0, rv0); end
    checks++; if (sc0 !== 32'd3 || sc1 !== 4'd3) begin errors++; $display("FAIL dwait_cnt: got %0d/%0d expected 3/3", sc0, sc1); end
    step();
    // back in RUN: a further 3-cycle wait must not trip the 4-cycle timeout
    dmem_ready = 0; step(); step(); step(); dmem_ready = 1; #1;
    checks++; if (mf0 !== 1'b0) begin errors++; $display("FAIL dwait_norun: got %b expected 0", mf0); end
    step();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_id = 1; #1;
    checks++; if (rv0 !== 5'b01000) begin errors++; $display("FAIL flush_mode: got %b expected 01000", rv0); end
    checks++; if (rv1 !== 5'b00000 || ev1 !== 5'b11111) begin errors++; $display("FAIL delay_slot: got rst=%b en=%b expected 00000/11111", rv1, ev1); end
    step();
    branch_taken_id = 0; #1;
    checks++; if (fc0 !== 32'd1 || fc1 !== 4'd0) begin errors++; $display("FAIL flush_cnt: got %0d/%0d expected 1/0", fc0, fc1); end
    branch_taken_id = 1; imem_ready = 0; #1;
    checks++; if (ev1 !== 5'b00111 || rv1 !== 5'b00100) begin errors++; $display("FAIL branch_iwait: got en=%b rst=%b expected 00111/00100", ev1, rv1); end
    step();
    checks++; if (fc0 !== 32'd1 || sc0 !== 32'd1) begin errors++; $display("FAIL branch_iwait_cnt: got f=%0d s=%0d expected 1/1", fc0, sc0); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req_mem = 1; dmem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (mf0 !== 1'b0 || ev0 !== 5'b00001) begin errors++; $display("FAIL timeout_pre_%0d: got f=%b en=%b expected 0/00001", k, mf0, ev0); end
      step();
    end
    #1;
    checks++; if (mf0 !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b expected 1", mf0); end
    checks++; if (ev0 !== 5'b00000 || rv0 !== 5'b00000) begin errors++; $display("FAIL timeout_freeze: got en=%b rst=%b expected 00000/00000", ev0, rv0); end
    step(); dmem_ready = 1; #1;
    checks++; if (ev0 !== 5'b00000 || sc0 !== 32'd4) begin errors++; $display("FAIL fault_sticky: got en=%b cnt=%0d expected 00000/4", ev0, sc0); end
    checks++; if (mf1 !== 1'b0 || sc1 !== 4'd5) begin errors++; $display("FAIL no_timeout: got f=%b cnt=%0d expected 0/5", mf1, sc1); end
    rst = 1; step(); rst = 0; clear_inputs(); #1;
    checks++; if (mf0 !== 1'b0 || sc0 !== 32'd0 || ev0 !== 5'b11111) begin errors++; $display("FAIL fault_clear: got f=%b cnt=%0d en=%b expected 0/0/11111", mf0, sc0, ev0); end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 0;
    for (int k = 0; k < 20; k++) step();
    imem_ready = 1; #1;
    checks++; if (sc1 !== 4'd15) begin errors++; $display("FAIL stall_sat: got %0d expected 15", sc1); end
    checks++; if (sc0 !== 32'd4 || mf0 !== 1'b1) begin errors++; $display("FAIL iwait_timeout: got cnt=%0d f=%b expected 4/1", sc0, mf0); end
    do_reset();
  endtask

  task automatic test_random();
    logic [4:0] f;
    int act;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 64) == 0;
      rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
      regw_addr_exe = 5'($urandom_range(0, 3)); regw_addr_mem = 5'($urandom_range(0, 3));
      rs_used = 1'($urandom); rt_used = 1'($urandom); is_store_id = 1'($urandom);
      branch_taken_id = ($urandom % 4) == 0;
      wb_wen_exe = 1'($urandom); wb_wen_mem = 1'($urandom);
      is_load_exe = 1'($urandom); is_load_mem = 1'($urandom);
      imem_ready = ($urandom % 6) != 0; dmem_req_mem = 1'($urandom);
      dmem_ready = ($urandom % 3) != 0;
      #1;
      f = exp_fwd();
      for (int d = 0; d < 2; d++) begin
        act = action(d);
        checks++;
        if ((d == 0 ? {fa0, fb0, fm0} : {fa1, fb1, fm1}) !== f) begin
          errors++; $display("FAIL rnd_fwd d%0d n%0d: got %b expected %b", d, n, (d == 0 ? {fa0, fb0, fm0} : {fa1, fb1, fm1}), f);
        end
        checks++;
        if ((d == 0 ? rv0 : rv1) !== exp_rst(act) || (d == 0 ? ev0 : ev1) !== exp_en(act)) begin
          errors++; $display("FAIL rnd_stage d%0d n%0d: got rst=%b en=%b expected %b/%b", d, n,
                             (d == 0 ? rv0 : rv1), (d == 0 ? ev0 : ev1), exp_rst(act), exp_en(act));
        end
      end
      checks++;
      if (mf0 !== m_fault[0] || sc0 !== m_stall[0][31:0] || fc0 !== m_flush[0][31:0]) begin
        errors++; $display("FAIL rnd_reg0 n%0d: got f=%b s=%0d fl=%0d expected %b/%0d/%0d", n, mf0, sc0, fc0, m_fault[0], m_stall[0], m_flush[0]);
      end
      checks++;
      if (mf1 !== m_fault[1] || sc1 !== m_stall[1][3:0] || fc1 !== m_flush[1][3:0]) begin
        errors++; $display("FAIL rnd_reg1 n%0d: got f=%b s=%0d fl=%0d expected %b/%0d/%0d", n, mf1, sc1, fc1, m_fault[1], m_stall[1], m_flush[1]);
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_fault[d] = 0; m_wc[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
    end
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_dwait();
    test_branch();
    test_timeout();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
